// File: rtl/datapath_pkg.sv
// Shared definitions for the ARM datapath pipeline stages: select-encoding
// modes, the two-entry skid buffer state names and a constant-foldable clog2.
package datapath_pkg;

  localparam int SEL_BINARY = 0;
  localparam int SEL_ONEHOT = 1;

  // Skid buffer occupancy, encoded as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_MAIN  = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Smallest r with 2**r >= n; used to size binary select codes.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Two-entry skid buffer with a fully registered valid/ready handshake.
// The main entry drives the outputs; the skid entry catches the beat that
// arrives in the cycle the downstream stalls, so in_ready never depends
// combinationally on out_ready.
module skid_buf_2
  import datapath_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_data;
  logic [W-1:0] skid_data;
  logic         main_valid;
  logic         skid_valid;
  logic         accept;
  logic         consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  // Occupancy state machine; the state is the pair of entry valid bits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset too, because out_data must read 0
      // during reset; storage that is never observed before being written
      // would normally be left unreset.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      case ({main_valid, skid_valid})
        SKID_EMPTY: begin
          if (accept) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
          end
        end
        SKID_MAIN: begin
          if (accept && consume) begin
            main_data <= in_data;
          end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
          end else if (consume) begin
            main_valid <= 1'b0;
          end
        end
        SKID_FULL: begin
          if (consume) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          // Skid-only occupancy is unreachable; fall back to empty.
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 operand-select stage for the ARM datapath. Decodes a binary or
// one-hot select, flags illegal codes, and registers {err, data} behind a
// two-entry skid buffer so the stage drops cleanly between pipeline stages.
module mux_nto1_pipe
  import datapath_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  NUM_IN   = 4,
  parameter int  SEL_MODE = SEL_BINARY,
  localparam int SEL_W    = (SEL_MODE == SEL_ONEHOT) ? NUM_IN : clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH:0]   buf_out;

  if (SEL_MODE == SEL_ONEHOT) begin : g_onehot
    // One-hot decode: exactly one set bit picks an operand, anything else is illegal.
    // NOTE: both outputs get a default before any branch, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      if ($countones(in_sel) == 1) begin
        for (int i = 0; i < NUM_IN; i++) begin
          if (in_sel[i]) begin
            sel_data = in_data[i*WIDTH +: WIDTH];
            sel_err  = 1'b0;
          end
        end
      end
    end
  end else begin : g_binary
    // Binary decode: codes NUM_IN..2**SEL_W-1 match no operand and stay illegal.
    always_comb begin
      sel_data = '0;
      sel_err  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (in_sel == SEL_W'(i)) begin
          sel_data = in_data[i*WIDTH +: WIDTH];
          sel_err  = 1'b0;
        end
      end
    end
  end

  // The error flag rides in the payload so it stays paired with its data.
  skid_buf_2 #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  ({sel_err, sel_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (buf_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_sel_err = buf_out[WIDTH];
  assign out_data    = buf_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: binary 4:1, binary 3:1 and one-hot 4:1
// instances, backpressure, mid-operation reset and a scoreboarded random phase.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Binary, NUM_IN=4
  logic [127:0] d4_in;
  logic [1:0]   d4_sel;
  logic         d4_iv, d4_ir, d4_oe, d4_ov, d4_or;
  logic [31:0]  d4_od;
  // Binary, NUM_IN=3
  logic [95:0]  d3_in;
  logic [1:0]   d3_sel;
  logic         d3_iv, d3_ir, d3_oe, d3_ov, d3_or;
  logic [31:0]  d3_od;
  // One-hot, NUM_IN=4
  logic [127:0] dh_in;
  logic [3:0]   dh_sel;
  logic         dh_iv, dh_ir, dh_oe, dh_ov, dh_or;
  logic [31:0]  dh_od;

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(0)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_data(d4_in), .in_sel(d4_sel),
    .in_valid(d4_iv), .in_ready(d4_ir), .out_data(d4_od), .out_sel_err(d4_oe),
    .out_valid(d4_ov), .out_ready(d4_or));

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_MODE(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(d3_in), .in_sel(d3_sel),
    .in_valid(d3_iv), .in_ready(d3_ir), .out_data(d3_od), .out_sel_err(d3_oe),
    .out_valid(d3_ov), .out_ready(d3_or));

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_MODE(1)) u_duth (
    .clk(clk), .reset_n(reset_n), .in_data(dh_in), .in_sel(dh_sel),
    .in_valid(dh_iv), .in_ready(dh_ir), .out_data(dh_od), .out_sel_err(dh_oe),
    .out_valid(dh_ov), .out_ready(dh_or));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ops[4];
  logic [31:0] oh_exp_d[4];
  logic        oh_exp_e[4];
  logic [3:0]  oh_sel[4];
  logic [32:0] sb[$];
  logic [32:0] exp_beat;
  logic [32:0] prev_out;
  logic        prev_stall;
  logic        hold;

  initial begin
    ops[0] = 32'h0000_0000; ops[1] = 32'hFFFF_FFFF;
    ops[2] = 32'hA5A5_A5A5; ops[3] = 32'h1234_5678;
    oh_sel[0] = 4'b0100; oh_exp_d[0] = 32'hA5A5_A5A5; oh_exp_e[0] = 1'b0;
    oh_sel[1] = 4'b0000; oh_exp_d[1] = 32'h0;         oh_exp_e[1] = 1'b1;
    oh_sel[2] = 4'b0110; oh_exp_d[2] = 32'h0;         oh_exp_e[2] = 1'b1;
    oh_sel[3] = 4'b0001; oh_exp_d[3] = 32'h0;         oh_exp_e[3] = 1'b0;

    reset_n = 1'b0;
    d4_in = '0; d4_sel = '0; d4_iv = 1'b0; d4_or = 1'b1;
    d3_in = '0; d3_sel = '0; d3_iv = 1'b0; d3_or = 1'b1;
    dh_in = '0; dh_sel = '0; dh_iv = 1'b0; dh_or = 1'b1;

    // Reset values, no clock edge yet
    #3;
    check("rst_out_valid", d4_ov, 1'b0);
    check("rst_out_data",  d4_od, 32'h0);
    check("rst_sel_err",   d4_oe, 1'b0);
    check("rst_in_ready",  d4_ir, 1'b1);
    #9 reset_n = 1'b1;

    // 1. Binary 4:1, first beat and back-to-back sweep
    d4_in = {ops[3], ops[2], ops[1], ops[0]};
    d4_sel = 2'd2; d4_iv = 1'b1; d4_or = 1'b1;
    step();
    check("t1_first_valid", d4_ov, 1'b1);
    check("t1_first_data",  d4_od, 32'hA5A5_A5A5);
    check("t1_first_err",   d4_oe, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d4_sel = 2'(i);
      step();
      check($sformatf("t1_sweep%0d", i), {d4_ov, d4_ir, d4_oe, d4_od},
            {1'b1, 1'b1, 1'b0, ops[i]});
    end
    d4_iv = 1'b0;
    step();
    check("t1_drained", d4_ov, 1'b0);

    // 2. Binary 3:1, unused code 3 is illegal
    d3_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    d3_sel = 2'd3; d3_iv = 1'b1;
    step();
    check("t2_sel3", {d3_ov, d3_oe, d3_od}, {1'b1, 1'b1, 32'h0});
    d3_sel = 2'd1;
    step();
    check("t2_sel1", {d3_ov, d3_oe, d3_od}, {1'b1, 1'b0, 32'h2222_2222});
    d3_iv = 1'b0;
    step();
    check("t2_drained", d3_ov, 1'b0);

    // 3. One-hot 4:1
    dh_in = {ops[3], ops[2], ops[1], ops[0]};
    dh_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dh_sel = oh_sel[i];
      step();
      check($sformatf("t3_onehot_%b", oh_sel[i]), {dh_ov, dh_oe, dh_od},
            {1'b1, oh_exp_e[i], oh_exp_d[i]});
    end
    dh_iv = 1'b0;
    step();

    // 4. Backpressure: two beats fill the buffer, then drain in order
    d4_sel = 2'd0; d4_or = 1'b0; d4_iv = 1'b1;
    d4_in = {96'h0, 32'h11};
    step();
    check("t4_one_beat", {d4_ov, d4_ir, d4_od}, {1'b1, 1'b1, 32'h11});
    d4_in = {96'h0, 32'h22};
    step();
    check("t4_full", {d4_ov, d4_ir, d4_od}, {1'b1, 1'b0, 32'h11});
    d4_iv = 1'b0;
    step();
    check("t4_hold", {d4_ov, d4_ir, d4_od}, {1'b1, 1'b0, 32'h11});
    d4_or = 1'b1;
    step();
    check("t4_second", {d4_ov, d4_ir, d4_od}, {1'b1, 1'b1, 32'h22});
    step();
    check("t4_empty", {d4_ov, d4_ir}, {1'b0, 1'b1});

    // 5. Reset while full
    d4_or = 1'b0; d4_iv = 1'b1;
    d4_in = {96'h0, 32'h44};
    step();
    d4_in = {96'h0, 32'h55};
    step();
    check("t5_full", d4_ir, 1'b0);
    d4_iv = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_rst", {d4_ov, d4_ir, d4_od}, {1'b1 ^ 1'b1, 1'b1, 32'h0});
    #2 reset_n = 1'b1;
    d4_or = 1'b1;
    step();
    step();
    check("t5_no_stale", d4_ov, 1'b0);
    d4_iv = 1'b1;
    d4_in = {96'h0, 32'h66};
    step();
    check("t5_fresh", {d4_ov, d4_oe, d4_od}, {1'b1, 1'b0, 32'h66});
    d4_iv = 1'b0;
    step();
    check("t5_fresh_drained", d4_ov, 1'b0);

    // 6. Random valid/ready against a scoreboard
    prev_stall = 1'b0;
    prev_out   = '0;
    hold       = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        d4_iv = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) ops[k] = $urandom;
        d4_in  = {ops[3], ops[2], ops[1], ops[0]};
        d4_sel = 2'($urandom_range(0, 3));
      end
      d4_or = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_stall)
        check("rand_stable", {d4_ov, d4_oe, d4_od}, {1'b1, prev_out});
      if (d4_ov && d4_or) begin
        if (sb.size() == 0) begin
          check("rand_spurious", d4_ov, 1'b0);
        end else begin
          exp_beat = sb.pop_front();
          check("rand_beat", {d4_oe, d4_od}, exp_beat);
        end
      end
      if (d4_iv && d4_ir) sb.push_back({1'b0, ops[d4_sel]});
      hold       = d4_iv && !d4_ir;
      prev_stall = d4_ov && !d4_or;
      prev_out   = {d4_oe, d4_od};
      step();
    end
    d4_iv = 1'b0;
    d4_or = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d4_ov) begin
        if (sb.size() == 0) begin
          check("drain_spurious", d4_ov, 1'b0);
        end else begin
          exp_beat = sb.pop_front();
          check("drain_beat", {d4_oe, d4_od}, exp_beat);
        end
      end
      step();
    end
    check("rand_no_loss", 64'(sb.size()), 64'd0);
    check("rand_end_idle", {d4_ov, d4_ir}, {1'b0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
